// File: rtl/score_pkg.sv
// score_pkg: identifiers shared by the score table controller.
//   - Player IDs carried with every score update (P_NONE marks an empty/bad ID).
//   - Source slot indices used by the pending slots and the arbiter.
//   - Bit positions of the ID field inside an external-link frame.
//   - bcd_valid(): checks that every nibble of a score is a decimal digit.
package score_pkg;

  localparam logic [1:0] P_NONE = 2'b00;
  localparam logic [1:0] P1     = 2'b01;
  localparam logic [1:0] P2     = 2'b10;
  localparam logic [1:0] P3     = 2'b11;

  localparam logic [1:0] SRC_LOC  = 2'd0;
  localparam logic [1:0] SRC_EXT1 = 2'd1;
  localparam logic [1:0] SRC_EXT2 = 2'd2;

  localparam int EXT_ID_LSB = 24;
  localparam int EXT_ID_MSB = 25;

  // Scores up to 8 digits are checked; narrower scores arrive zero-extended,
  // and zero nibbles are valid digits.
  localparam int BCD_MAX_DIGITS = 8;

  function automatic logic bcd_valid(input logic [31:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/score_table_ctrl_if.sv
// score_table_ctrl_if: score sources feeding the score table controller.
//   loc_valid/loc_points   local board score strobe + BCD score
//   ext1_valid/ext1_data   link 1 frame: [25:24] player ID, [23:0] BCD score
//   ext2_valid/ext2_data   link 2 frame, same format
// master drives the sources, slave (the controller) receives them.
interface score_table_ctrl_if #(
  parameter int DIGITS = 6
);
  logic                  loc_valid;
  logic [4*DIGITS-1:0]   loc_points;
  logic                  ext1_valid;
  logic [31:0]           ext1_data;
  logic                  ext2_valid;
  logic [31:0]           ext2_data;

  modport master (
    output loc_valid, loc_points, ext1_valid, ext1_data, ext2_valid, ext2_data
  );

  modport slave (
    input loc_valid, loc_points, ext1_valid, ext1_data, ext2_valid, ext2_data
  );
endinterface

// File: rtl/score_rr_arb3.sv
// score_rr_arb3: 3-way round-robin arbiter.
//   clk, rst_n   clock, asynchronous active-low reset
//   req[2:0]     pending requests, index = source slot
//   gnt[2:0]     one-hot grant (combinational from req and pointer)
//   gnt_idx      index of the granted slot
//   gnt_vld      a grant is issued this cycle
// Search starts one past the last granted slot; the pointer resets to slot 2,
// so the first order after reset is slot 0, 1, 2.
module score_rr_arb3
  import score_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld
);

  logic [1:0] ptr_r;

  // Rotating-priority one-hot grant selection
  always_comb begin
    gnt = 3'b000;
    case (ptr_r)
      SRC_LOC: begin
        if      (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else             gnt = 3'b000;
      end
      SRC_EXT1: begin
        if      (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else             gnt = 3'b000;
      end
      default: begin
        if      (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else             gnt = 3'b000;
      end
    endcase
  end

  // One-hot grant to slot index
  always_comb begin
    gnt_vld = |gnt;
    case (gnt)
      3'b010:  gnt_idx = SRC_EXT1;
      3'b100:  gnt_idx = SRC_EXT2;
      default: gnt_idx = SRC_LOC;
    endcase
  end

  // Remember the last granted slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= SRC_EXT2;
    end else if (gnt_vld) begin
      ptr_r <= gnt_idx;
    end
  end

endmodule

// File: rtl/score_table_ctrl.sv
// score_table_ctrl: collects BCD scores from the local board and two links,
// arbitrates them into a per-player working table and publishes frame-stable
// copies at frame_start.
//   clk, rst_n        clock, asynchronous active-low reset
//   frame_start       vblank pulse; output shadow update point
//   board_ID          player ID of the local board
//   src               score sources (score_table_ctrl_if.slave)
//   p1/p2/p3_score    frame-stable BCD scores
//   stale[2:0]        player k+1 not updated for STALE_FRAMES frames
//   table_upd         one-cycle pulse when the shadowed scores changed
//   drop_err          sticky: frame dropped (bad ID, non-BCD, overwrite)
//   leader            highest-scoring player; only built with SCORE_LEADER_EN,
//                     otherwise tied to 2'b00
module score_table_ctrl
  import score_pkg::*;
#(
  parameter int DIGITS       = 6,
  parameter int STALE_FRAMES = 120
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic [1:0]           board_ID,
  score_table_ctrl_if.slave    src,
  output logic [4*DIGITS-1:0]  p1_score,
  output logic [4*DIGITS-1:0]  p2_score,
  output logic [4*DIGITS-1:0]  p3_score,
  output logic [2:0]           stale,
  output logic                 table_upd,
  output logic                 drop_err,
  output logic [1:0]           leader
);

  localparam int         W         = 4*DIGITS;
  localparam logic [7:0] STALE_CNT = 8'(STALE_FRAMES);

  logic [2:0]   in_vld_s;
  logic [1:0]   in_id_s   [3];
  logic [W-1:0] in_bcd_s  [3];
  logic [2:0]   pend_vld_r;
  logic [1:0]   pend_id_r [3];
  logic [W-1:0] pend_bcd_r[3];
  logic [2:0]   gnt_s;
  logic [1:0]   gnt_idx_s;
  logic         gnt_vld_s;
  logic [1:0]   g_id_s;
  logic [W-1:0] g_bcd_s;
  logic         g_ok_s;
  logic         g_bad_s;
  logic [2:0]   ovw_s;
  logic [2:0]   wr_s;
  logic         changed_s;
  logic [W-1:0] table_r [3];
  logic [W-1:0] shadow_r[3];
  logic [7:0]   cnt_r   [3];
  logic [2:0]   stale_r;
  logic         table_upd_r;
  logic         drop_err_r;
  logic         unused_bits_s;

  // Link frame bits above the ID field carry nothing for this block
  assign unused_bits_s = ^{src.ext1_data[31:EXT_ID_MSB+1], src.ext2_data[31:EXT_ID_MSB+1]};

  // Normalise the three sources into {valid, id, bcd} slots
  always_comb begin
    in_vld_s           = {src.ext2_valid, src.ext1_valid, src.loc_valid};
    in_id_s[SRC_LOC]   = board_ID;
    in_bcd_s[SRC_LOC]  = src.loc_points;
    in_id_s[SRC_EXT1]  = src.ext1_data[EXT_ID_MSB:EXT_ID_LSB];
    in_bcd_s[SRC_EXT1] = src.ext1_data[W-1:0];
    in_id_s[SRC_EXT2]  = src.ext2_data[EXT_ID_MSB:EXT_ID_LSB];
    in_bcd_s[SRC_EXT2] = src.ext2_data[W-1:0];
  end

  score_rr_arb3 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (pend_vld_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .gnt_vld (gnt_vld_s)
  );

  // Pick the granted slot and classify it as writable or to be dropped
  always_comb begin
    case (gnt_idx_s)
      SRC_LOC:  begin g_id_s = pend_id_r[0]; g_bcd_s = pend_bcd_r[0]; end
      SRC_EXT1: begin g_id_s = pend_id_r[1]; g_bcd_s = pend_bcd_r[1]; end
      SRC_EXT2: begin g_id_s = pend_id_r[2]; g_bcd_s = pend_bcd_r[2]; end
      default:  begin g_id_s = P_NONE;       g_bcd_s = {W{1'b0}};     end
    endcase
    g_ok_s  = gnt_vld_s && (g_id_s != P_NONE) && bcd_valid(32'(g_bcd_s));
    g_bad_s = gnt_vld_s && !g_ok_s;
    // A new strobe only counts as an overwrite if the slot is not leaving this edge
    ovw_s   = in_vld_s & pend_vld_r & ~gnt_s;
  end

  // One-hot table row written by the granted entry
  always_comb begin
    wr_s = 3'b000;
    if (g_ok_s) begin
      case (g_id_s)
        P1:      wr_s = 3'b001;
        P2:      wr_s = 3'b010;
        P3:      wr_s = 3'b100;
        default: wr_s = 3'b000;
      endcase
    end else begin
      wr_s = 3'b000;
    end
    changed_s = (table_r[0] != shadow_r[0]) || (table_r[1] != shadow_r[1]) ||
                (table_r[2] != shadow_r[2]);
  end

  // Pending slots: latest strobe wins, grant empties the slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_r <= 3'b000;
      for (int k = 0; k < 3; k++) begin
        pend_id_r[k]  <= P_NONE;
        pend_bcd_r[k] <= {W{1'b0}};
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (in_vld_s[k]) begin
          pend_vld_r[k] <= 1'b1;
          pend_id_r[k]  <= in_id_s[k];
          pend_bcd_r[k] <= in_bcd_s[k];
        end else if (gnt_s[k]) begin
          pend_vld_r[k] <= 1'b0;
        end
      end
    end
  end

  // Working table and sticky drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err_r <= 1'b0;
      for (int k = 0; k < 3; k++) table_r[k] <= {W{1'b0}};
    end else begin
      if ((|ovw_s) || g_bad_s) drop_err_r <= 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (wr_s[k]) table_r[k] <= g_bcd_s;
      end
    end
  end

  // Frame shadow: outputs only move at frame_start, so the overlay never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      table_upd_r <= 1'b0;
      for (int k = 0; k < 3; k++) shadow_r[k] <= {W{1'b0}};
    end else if (frame_start) begin
      table_upd_r <= changed_s;
      for (int k = 0; k < 3; k++) shadow_r[k] <= table_r[k];
    end else begin
      table_upd_r <= 1'b0;
    end
  end

  // Per-player frames-since-update counters; a write beats a same-edge frame tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stale_r <= 3'b000;
      for (int k = 0; k < 3; k++) cnt_r[k] <= 8'd0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (wr_s[k]) begin
          cnt_r[k]   <= 8'd0;
          stale_r[k] <= 1'b0;
        end else if (frame_start && (cnt_r[k] != STALE_CNT)) begin
          cnt_r[k]   <= cnt_r[k] + 8'd1;
          stale_r[k] <= ((cnt_r[k] + 8'd1) == STALE_CNT);
        end
      end
    end
  end

`ifdef SCORE_LEADER_EN
  logic [1:0]   lead_s;
  logic [W-1:0] best_s;
  logic [1:0]   leader_r;

  // Argmax over the values being shadowed. Valid BCD orders like binary, so a
  // plain unsigned compare works; strict '>' leaves ties on the lower ID.
  always_comb begin
    lead_s = P_NONE;
    best_s = {W{1'b0}};
    if (table_r[0] > best_s) begin
      lead_s = P1;
      best_s = table_r[0];
    end else begin
      lead_s = P_NONE;
    end
    if (table_r[1] > best_s) begin
      lead_s = P2;
      best_s = table_r[1];
    end else begin
      // earlier leader stays
    end
    if (table_r[2] > best_s) begin
      lead_s = P3;
      best_s = table_r[2];
    end else begin
      // earlier leader stays
    end
  end

  // Leader follows the shadowed scores
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leader_r <= P_NONE;
    end else if (frame_start) begin
      leader_r <= lead_s;
    end
  end

  assign leader = leader_r;
`else
  assign leader = P_NONE;
`endif

  assign p1_score  = shadow_r[0];
  assign p2_score  = shadow_r[1];
  assign p3_score  = shadow_r[2];
  assign stale     = stale_r;
  assign table_upd = table_upd_r;
  assign drop_err  = drop_err_r;

endmodule
